// File: rtl/bus_fifo_pkg.sv
// Shared types and constants for the bus driver FIFO bank.
// Optional per-channel pop statistics are enabled with BUS_FIFO_STATS_EN.
package bus_fifo_pkg;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST = 8'hFF;

  typedef enum logic {
    OVF_REJECT    = 1'b0,
    OVF_OVERWRITE = 1'b1
  } ovf_mode_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/bus_fifo_chan.sv
// One terminal channel: transmit FIFO with overflow policy, receive capture with ID check.
// Pop statistics counter is compiled only when BUS_FIFO_STATS_EN is defined.
module bus_fifo_chan
  import bus_fifo_pkg::*;
#(
  parameter int        IDX       = 0,
  parameter int        PCKG_SZ   = 16,
  parameter int        DEEP      = 8,
  parameter int        AFULL_THR = DEEP - 1,
  parameter ovf_mode_e OVF_MODE  = OVF_REJECT
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               wr_en_i,
  input  logic [PCKG_SZ-1:0] wr_data_i,
  output logic               full_o,
  output logic               afull_o,
  output logic               pndng_o,
  output logic [PCKG_SZ-1:0] d_pop_o,
  input  logic               pop_i,
  input  logic               push_i,
  input  logic [PCKG_SZ-1:0] d_push_i,
  output logic               rx_valid_o,
  output logic [PCKG_SZ-1:0] rx_data_o,
  output logic               ovf_flag_o,
  output logic               udf_flag_o,
  output logic               id_err_o,
  output logic [15:0]        stat_cnt_o
);
  localparam int CW = cnt_width(DEEP);
  localparam int PW = (DEEP > 1) ? $clog2(DEEP) : 1;

  logic [PCKG_SZ-1:0] mem_q [DEEP];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rx_valid_q, rx_valid_d;
  logic [PCKG_SZ-1:0] rx_data_q, rx_data_d;
  logic               ovf_q, ovf_d, udf_q, udf_d, id_err_q, id_err_d;
  logic               empty, is_full, do_pop, do_wr, ovf_ev, adv_head;
  logic [ID_W-1:0]    rx_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEEP - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty    = (cnt_q == '0);
    is_full  = (cnt_q == CW'(DEEP));
    do_pop   = pop_i && !empty;
    // A full write with a simultaneous pop is an ordinary write, not an overflow.
    ovf_ev   = wr_en_i && is_full && !pop_i;
    do_wr    = wr_en_i && (!ovf_ev || (OVF_MODE == OVF_OVERWRITE));
    adv_head = do_pop || (ovf_ev && (OVF_MODE == OVF_OVERWRITE));

    wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = adv_head ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr && !adv_head) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_wr && adv_head) begin
      cnt_d = cnt_q - 1'b1;
    end

    rx_id      = d_push_i[PCKG_SZ-1 -: ID_W];
    rx_valid_d = push_i;
    rx_data_d  = push_i ? d_push_i : rx_data_q;
    ovf_d      = ovf_q | ovf_ev;
    udf_d      = udf_q | (pop_i && empty);
    id_err_d   = id_err_q | (push_i && (rx_id != ID_W'(IDX)) && (rx_id != BCAST));
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      id_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      id_err_q   <= id_err_d;
    end
  end

  // Storage needs no reset; d_pop_o is masked while the channel is empty.
  always_ff @(posedge clk_i) begin
    if (reset_i && do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign full_o     = is_full;
  assign afull_o    = (cnt_q >= CW'(AFULL_THR));
  assign pndng_o    = !empty;
  assign d_pop_o    = empty ? '0 : mem_q[rd_ptr_q];
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign ovf_flag_o = ovf_q;
  assign udf_flag_o = udf_q;
  assign id_err_o   = id_err_q;

`ifdef BUS_FIFO_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (do_pop && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt_o = stat_q;
`else
  assign stat_cnt_o = '0;
`endif
endmodule

// File: rtl/bus_drvr_fifo_bank.sv
// Bank of independent per-terminal FIFO channels between the agents and the bus.
// Define BUS_FIFO_STATS_EN to enable the per-channel stat_cnt pop counters.
module bus_drvr_fifo_bank
  import bus_fifo_pkg::*;
#(
  parameter int pckg_sz   = 16,
  parameter int deep_fifo = 8,
  parameter int drvrs     = 4,
  parameter int afull_thr = deep_fifo - 1,
  parameter int ovf_mode  = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                wr_en,
  input  logic [drvrs-1:0][pckg_sz-1:0]   wr_data,
  output logic [drvrs-1:0]                full,
  output logic [drvrs-1:0]                afull,
  output logic [drvrs-1:0]                pndng,
  output logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  input  logic [drvrs-1:0]                pop,
  input  logic [drvrs-1:0]                push,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_push,
  output logic [drvrs-1:0]                rx_valid,
  output logic [drvrs-1:0][pckg_sz-1:0]   rx_data,
  output logic [drvrs-1:0]                ovf_flag,
  output logic [drvrs-1:0]                udf_flag,
  output logic [drvrs-1:0]                id_err,
  output logic [drvrs-1:0][15:0]          stat_cnt
);
  localparam ovf_mode_e OVF_SEL = (ovf_mode != 0) ? OVF_OVERWRITE : OVF_REJECT;

  for (genvar g = 0; g < drvrs; g++) begin : g_chan
    bus_fifo_chan #(
      .IDX       (g),
      .PCKG_SZ   (pckg_sz),
      .DEEP      (deep_fifo),
      .AFULL_THR (afull_thr),
      .OVF_MODE  (OVF_SEL)
    ) u_chan (
      .clk_i      (clk),
      .reset_i    (reset),
      .wr_en_i    (wr_en[g]),
      .wr_data_i  (wr_data[g]),
      .full_o     (full[g]),
      .afull_o    (afull[g]),
      .pndng_o    (pndng[g]),
      .d_pop_o    (D_pop[g]),
      .pop_i      (pop[g]),
      .push_i     (push[g]),
      .d_push_i   (D_push[g]),
      .rx_valid_o (rx_valid[g]),
      .rx_data_o  (rx_data[g]),
      .ovf_flag_o (ovf_flag[g]),
      .udf_flag_o (udf_flag[g]),
      .id_err_o   (id_err[g]),
      .stat_cnt_o (stat_cnt[g])
    );
  end
endmodule

// File: doc/bus_drvr_fifo_bank.md
Name: bus_drvr_fifo_bank

Overview:
Parametrised bank of per-terminal FIFOs between the agent side and the N-terminal bus generator/arbiter.
- Each channel buffers outgoing packets and presents them to the bus with the pndng/pop/D_pop handshake.
- Each channel also captures incoming push/D_push traffic with destination-ID checking.
- Adds selectable overflow policy, almost-full, underflow and ID-mismatch flags, and optional per-channel statistics.

Parameters:
pckg_sz, 16, packet width in bits; upper ID_W bits = destination ID
deep_fifo, 8, words per channel FIFO (>=2, any integer)
drvrs, 4, number of terminals/channels
afull_thr, deep_fifo-1, count at or above which afull[i] asserts
ovf_mode, 0, 0 = reject new word when full; 1 = overwrite oldest

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous reset, active-low
wr_en  in  drvrs  agent write strobe per channel
wr_data  in  drvrs x pckg_sz  agent write data per channel
full  out  drvrs  channel count == deep_fifo
afull  out  drvrs  channel count >= afull_thr
pndng  out  drvrs  channel non-empty (to bus)
D_pop  out  drvrs x pckg_sz  head word of channel, show-ahead (to bus)
pop  in  drvrs  bus consumes head word
push  in  drvrs  bus delivers word to terminal
D_push  in  drvrs x pckg_sz  delivered word
rx_valid  out  drvrs  one-cycle pulse, registered capture of push
rx_data  out  drvrs x pckg_sz  last captured D_push
ovf_flag  out  drvrs  sticky: a write was rejected or overwrote data
udf_flag  out  drvrs  sticky: pop seen while empty
id_err  out  drvrs  sticky: received ID not own index and not BCAST
stat_cnt  out  drvrs x 16  per-channel popped-word count (see Optional Feature)

Behaviour:
- Reset: sampled on the clk edge while reset==0. Clears all counts and pointers. All outputs go to 0 the next cycle: pndng, full, afull, rx_valid, flags, rx_data, stat_cnt. D_pop = 0 while empty.
- Channels are fully independent; no cross-channel ordering.
- Write latency: word written at edge N is visible on D_pop and pndng after edge N (one-cycle latency).
- pop[i] at edge N with count>0: head advances; next word (or 0 if now empty) is valid after edge N. D_pop is driven from storage with no registered output stage.
- Pointers wrap from deep_fifo-1 to 0; non-power-of-2 depth must wrap correctly.
- Count width is $clog2(deep_fifo+1).
- Simultaneous wr_en and pop, count between 1 and deep_fifo-1: both occur, count unchanged.
- Simultaneous wr_en and pop while full: both occur, count stays deep_fifo, no overflow.
- Simultaneous wr_en and pop while empty: write occurs, pop ignored, udf_flag set.
- wr_en while full without pop, ovf_mode=0: word dropped, contents unchanged, ovf_flag set.
- wr_en while full without pop, ovf_mode=1: oldest word discarded (head advances), new word stored, count stays deep_fifo, ovf_flag set.
- pop while empty: no state change other than udf_flag set.
- Receive path: push[i] at edge N loads rx_data[i] = D_push[i] and pulses rx_valid[i] for the cycle after edge N.
- Receive ID check: if D_push[i][pckg_sz-1 -: ID_W] != i and != BCAST, id_err[i] is set. Data is still captured.
- Sticky flags clear only on reset.

Optional Feature:
BUS_FIFO_STATS_EN
- Defined: stat_cnt[i] increments on each successful pop (count>0). It saturates at 16'hFFFF and clears on reset.
- Undefined: counter logic is not compiled and stat_cnt is tied to 0. The port list is identical in both builds.

Decomposition:
- Package bus_fifo_pkg holds: ID_W = 8; BCAST = 8'hFF; ovf_mode_e {OVF_REJECT=0, OVF_OVERWRITE=1}; function returning the count width.
- Sub-module bus_fifo_chan implements one channel (FIFO, receive capture, flags, stat counter).
- The top instantiates bus_fifo_chan drvrs times in a generate loop, passing the channel index as a parameter for the ID check.

Test Plan:
1. Reset, then write 16'h0202 on ch1 -> pndng[1]=1 and D_pop[1]=16'h0202 after one edge; pop[1] -> pndng[1]=0, D_pop[1]=0.
2. ch0: write 8 words 16'h0300..16'h0307 -> full[0]=1 and afull[0]=1 from 7 words. With ovf_mode=0, write 16'h03FF -> ovf_flag[0]=1 and pops return 0300..0307. With ovf_mode=1, the same write makes pops return 0301..0307 then 03FF.
3. ch2 full; wr_en and pop in the same cycle with 16'hAAAA -> count stays 8, no ovf_flag, last pop returns AAAA.
4. Pop on empty ch3 together with a write of 16'h0101 -> udf_flag[3]=1; D_pop[3]=16'h0101 next cycle.
5. push[2] with D_push=16'h0205 -> rx_valid[2] one-cycle pulse, rx_data[2]=0205, id_err[2]=0. Then D_push=16'h0105 -> id_err[2]=1. Then 16'hFF05 on ch0 -> id_err[0]=0.
6. Assert reset low mid-burst on ch1 (4 words queued) -> all outputs 0 next cycle. With BUS_FIFO_STATS_EN, stat_cnt[1] counts 3 after 3 pops before the reset and reads 0 after it.
